// File: rtl/veda_memory_param.sv
`default_nettype none
// ============================================================================
// Module      : veda_memory_param
// Description : Single-clock data memory with one byte-enabled write port (A)
//               and one registered read port (B). Write-first forwarding on
//               address collision, a hardware clear sweep after reset or on
//               command, range checking and a ready indication.
// Revision    : 1.0 - initial release
// ============================================================================
module veda_memory_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_in,
    input  logic [BE_W-1:0]   byte_en,
    input  logic              write_enable,
    input  logic [1:0]        mode,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_err;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_mem_wr;
    logic              w_clr_wr;
    logic              w_rd_en;
    logic              w_err_nxt;
    logic              w_a_in_range;
    logic              w_b_in_range;
    logic              w_wr_req;
    logic              w_rd_req;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_fwd_word;

    assign w_a_in_range = ({1'b0, address_a} < c_depth);
    assign w_b_in_range = ({1'b0, address_b} < c_depth);
    assign w_wr_req     = write_enable && ((mode == 2'b00) || (mode == 2'b10));
    assign w_rd_req     = (mode == 2'b01) || (mode == 2'b10);
    assign w_rd_word    = r_mem[address_b];

    // Next state, sweep pointer and per-port accept/reject decisions
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_wr    = 1'b0;
        w_clr_wr    = 1'b0;
        w_rd_en     = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_wr  = 1'b1;
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == c_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end
                // Anything that looks like a request while busy is rejected
                w_err_nxt = write_enable || w_rd_req;
            end
            S_IDLE: begin
                if (mode == 2'b11) begin
                    if (write_enable) begin
                        w_state_nxt = S_CLEAR;
                        w_ptr_nxt   = '0;
                    end
                end else begin
                    w_mem_wr  = w_wr_req && w_a_in_range;
                    w_rd_en   = w_rd_req && w_b_in_range;
                    w_err_nxt = (w_wr_req && !w_a_in_range) ||
                                (w_rd_req && !w_b_in_range);
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Write-first forwarding: bytes being written to the read address this cycle
    always_comb begin
        w_fwd_word = w_rd_word;
        for (int i = 0; i < BE_W; i++) begin
            if (w_mem_wr && (address_a == address_b) && byte_en[i]) begin
                w_fwd_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Memory array: clear sweep has priority, otherwise byte-enabled write
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_clr_wr) begin
                r_mem[r_ptr] <= '0;
            end else if (w_mem_wr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (byte_en[i]) begin
                        r_mem[address_a][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    // State register, sweep pointer and registered read-side outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_ptr        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_data_valid <= w_rd_en;
            r_err        <= w_err_nxt;
            if (w_rd_en) begin
                r_data_out <= w_fwd_word;
            end
        end
    end

    assign ready      = (r_state == S_IDLE);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_veda_memory_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_veda_memory_param
// Description : Self-checking bench for veda_memory_param. Two instances
//               (DEPTH 32 and DEPTH 20) share the stimulus; a behavioural
//               model tracks both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_veda_memory_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  address_a, address_b;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic        write_enable;
    logic [1:0]  mode;

    logic        ready32, dv32, err32;
    logic [31:0] dout32;
    logic        ready20, dv20, err20;
    logic [31:0] dout20;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    veda_memory_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut32 (
        .clk(clk), .reset(reset), .address_a(address_a), .address_b(address_b),
        .data_in(data_in), .byte_en(byte_en), .write_enable(write_enable),
        .mode(mode), .ready(ready32), .data_out(dout32), .data_valid(dv32), .err(err32)
    );

    veda_memory_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) dut20 (
        .clk(clk), .reset(reset), .address_a(address_a), .address_b(address_b),
        .data_in(data_in), .byte_en(byte_en), .write_enable(write_enable),
        .mode(mode), .ready(ready20), .data_out(dout20), .data_valid(dv20), .err(err20)
    );

    // Behavioural model: index 0 = DEPTH 32, index 1 = DEPTH 20
    int          dep [2] = '{32, 20};
    logic [31:0] mm  [2][32];
    bit          busy[2];
    int          rem [2];
    logic [31:0] m_dout[2];
    bit          m_dv [2];
    bit          m_err[2];

    task automatic start_sweep(input int k);
        busy[k] = 1'b1;
        rem[k]  = dep[k];
        for (int j = 0; j < 32; j++) mm[k][j] = 32'h0;
    endtask

    task automatic model_step(input int k);
        bit wr, rd;
        wr = write_enable && (mode == 2'd0 || mode == 2'd2);
        rd = (mode == 2'd1 || mode == 2'd2);
        if (!reset) begin
            start_sweep(k);
            m_dout[k] = 32'h0;
            m_dv[k]   = 1'b0;
            m_err[k]  = 1'b0;
        end else if (busy[k]) begin
            m_err[k] = write_enable || rd;
            m_dv[k]  = 1'b0;
            rem[k]--;
            if (rem[k] == 0) busy[k] = 1'b0;
        end else begin
            m_err[k] = 1'b0;
            m_dv[k]  = 1'b0;
            if (mode == 2'd3) begin
                if (write_enable) start_sweep(k);
            end else begin
                if (wr) begin
                    if (int'(address_a) < dep[k]) begin
                        for (int i = 0; i < 4; i++)
                            if (byte_en[i]) mm[k][address_a][8*i +: 8] = data_in[8*i +: 8];
                    end else m_err[k] = 1'b1;
                end
                if (rd) begin
                    if (int'(address_b) < dep[k]) begin
                        m_dout[k] = mm[k][address_b];
                        m_dv[k]   = 1'b1;
                    end else m_err[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model ready32", {31'd0, ready32}, {31'd0, !busy[0]});
        chk("model dout32",  dout32, m_dout[0]);
        chk("model dv32",    {31'd0, dv32},  {31'd0, m_dv[0]});
        chk("model err32",   {31'd0, err32}, {31'd0, m_err[0]});
        chk("model ready20", {31'd0, ready20}, {31'd0, !busy[1]});
        chk("model dout20",  dout20, m_dout[1]);
        chk("model dv20",    {31'd0, dv20},  {31'd0, m_dv[1]});
        chk("model err20",   {31'd0, err20}, {31'd0, m_err[1]});
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge, compare 1 ns later
    task automatic cycle(input logic rn, input logic [1:0] md, input logic we,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        reset = rn; mode = md; write_enable = we;
        address_a = a; address_b = b; data_in = d; byte_en = be;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0);
    endtask

    typedef struct {
        logic [1:0]  md;
        logic        we;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_dout;
        logic        exp_dv;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        // Directed vectors against the DEPTH-32 instance; memory starts all zero
        vecs[0]  = '{2'd0, 1'b1, 5'd5,  5'd0,  32'h12345678, 4'hF, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 1'b1, 5'd10, 5'd0,  32'h87654321, 4'hF, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 1'b0, 5'd0,  5'd5,  32'h0,        4'h0, 32'h12345678, 1'b1, 1'b0};
        vecs[3]  = '{2'd1, 1'b0, 5'd0,  5'd10, 32'h0,        4'h0, 32'h87654321, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 1'b1, 5'd5,  5'd0,  32'hAABBCCDD, 4'h2, 32'h87654321, 1'b0, 1'b0};
        vecs[5]  = '{2'd1, 1'b0, 5'd0,  5'd5,  32'h0,        4'h0, 32'h1234CC78, 1'b1, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, 5'd3,  5'd3,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[7]  = '{2'd0, 1'b0, 5'd0,  5'd0,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 1'b1, 5'd6,  5'd3,  32'h01020304, 4'h1, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[9]  = '{2'd1, 1'b0, 5'd0,  5'd6,  32'h0,        4'h0, 32'h00000004, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 1'b1, 5'd6,  5'd6,  32'hFFFFFFFF, 4'h8, 32'hFF000004, 1'b1, 1'b0};
        vecs[11] = '{2'd1, 1'b1, 5'd0,  5'd10, 32'h0,        4'h0, 32'h87654321, 1'b1, 1'b0};

        reset = 1'b0; mode = 2'd0; write_enable = 1'b0;
        address_a = '0; address_b = '0; data_in = '0; byte_en = '0;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0);
        chk("reset ready", {31'd0, ready32}, 32'd0);
        chk("reset dout",  dout32, 32'd0);
        chk("reset dv",    {31'd0, dv32}, 32'd0);
        chk("reset err",   {31'd0, err32}, 32'd0);

        // Sweep length after reset release
        n = 0;
        while (n < 100) begin
            idle();
            n++;
            if (ready32) break;
        end
        chk("sweep cycles after reset", n, 32);
        cycle(1'b1, 2'd1, 1'b0, 5'd0, 5'd7, 32'h0, 4'h0);
        chk("read 7 dout", dout32, 32'h0);
        chk("read 7 dv", {31'd0, dv32}, 32'd1);

        // Table-driven write/read/forwarding vectors
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].md, vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].be);
            chk($sformatf("vec%0d dout", i), dout32, vecs[i].exp_dout);
            chk($sformatf("vec%0d dv", i),  {31'd0, dv32},  {31'd0, vecs[i].exp_dv});
            chk($sformatf("vec%0d err", i), {31'd0, err32}, {31'd0, vecs[i].exp_err});
        end

        // Out-of-range on the DEPTH-20 instance
        cycle(1'b1, 2'd0, 1'b1, 5'd25, 5'd0, 32'h55555555, 4'hF);
        chk("oor write err20", {31'd0, err20}, 32'd1);
        chk("oor write err32", {31'd0, err32}, 32'd0);
        cycle(1'b1, 2'd1, 1'b0, 5'd0, 5'd25, 32'h0, 4'h0);
        chk("oor read err20", {31'd0, err20}, 32'd1);
        chk("oor read dv20",  {31'd0, dv20},  32'd0);
        chk("in-range read dout32", dout32, 32'h55555555);
        cycle(1'b1, 2'd2, 1'b1, 5'd25, 5'd3, 32'h66666666, 4'hF);
        chk("mixed err20", {31'd0, err20}, 32'd1);
        chk("mixed dv20",  {31'd0, dv20},  32'd1);
        chk("mixed dout20", dout20, 32'hDEADBEEF);

        // Clear command, request during sweep, reset mid-sweep
        cycle(1'b1, 2'd3, 1'b1, 5'd0, 5'd0, 32'h0, 4'h0);
        chk("clear ready", {31'd0, ready32}, 32'd0);
        cycle(1'b1, 2'd1, 1'b0, 5'd0, 5'd5, 32'h0, 4'h0);
        chk("busy read err", {31'd0, err32}, 32'd1);
        chk("busy read dv",  {31'd0, dv32},  32'd0);
        chk("dout held during sweep", dout32, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) idle();
        cycle(1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0);
        n = 0;
        while (n < 100) begin
            idle();
            n++;
            if (ready32) break;
        end
        chk("sweep cycles after mid-sweep reset", n, 32);
        cycle(1'b1, 2'd1, 1'b0, 5'd0, 5'd5, 32'h0, 4'h0);
        chk("addr 5 cleared", dout32, 32'h0);
        chk("addr 5 cleared dv", {31'd0, dv32}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] md;
            logic       rn;
            md = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) md = 2'd3;
            rn = ($urandom_range(0, 199) != 0);
            cycle(rn, md, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  $urandom, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
